lattice_result_collector: RTL and testbench

Sits at the tail of the hashing lattice, on the consuming side of the final block's results: it reads the per-round result stream (`validOut`/`newBlockOut` plus success and winning-core index) and turns it into absolute nonces. It tracks the nonce base of each round, queues winning nonces in a small FIFO, and hands them to the host controller over a valid/ready handshake. It also reports nonce-space exhaustion.

---
 rtl/lattice_result_collector_if.sv | 30 +++
 rtl/lattice_result_collector.sv | 117 +++++++++++
 tb/tb_lattice_result_collector.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lattice_result_collector_if.sv
// Handshake/result bundle between the lattice tail, the collector and the host.
// Valid/ready: the host owns nonce_ready_i, and a head nonce transfers on any cycle where nonce_valid_o && nonce_ready_i.
interface lattice_result_collector_if #(
    parameter int NUM_CORES  = 10,
    parameter int NONCE_BITS = 32
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                  valid_i;
    logic                  new_block_i;
    logic                  success_i;
    logic [IW-1:0]         core_index_i;
    logic [NONCE_BITS-1:0] nonce_o;
    logic                  nonce_valid_o;
    logic                  nonce_ready_i;
    logic                  block_done_o;
    logic                  overflow_o;
    logic [15:0]           found_count_o;
    logic [1:0]            state_o;

    modport slave (
        input  valid_i, new_block_i, success_i, core_index_i, nonce_ready_i,
        output nonce_o, nonce_valid_o, block_done_o, overflow_o, found_count_o, state_o
    );

    modport master (
        output valid_i, new_block_i, success_i, core_index_i, nonce_ready_i,
        input  nonce_o, nonce_valid_o, block_done_o, overflow_o, found_count_o, state_o
    );
endinterface

// File: rtl/lattice_result_collector.sv
// Turns per-round lattice results into absolute winning nonces queued for the host.
// Optional LATTICE_COLLECT_FLUSH_EN: a new-block round discards any queued winners first.
module lattice_result_collector #(
    parameter int NUM_CORES  = 10,
    parameter int NONCE_BITS = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    lattice_result_collector_if.slave bus
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [NONCE_BITS:0]   SPAN      = (NONCE_BITS+1)'(2*NUM_CORES - 1);
    localparam logic [NONCE_BITS-1:0] STEP      = NONCE_BITS'(NUM_CORES);
    localparam logic [AW:0]           DEPTH     = (AW+1)'(FIFO_DEPTH);
    localparam logic [IW:0]           CORES_LIM = (IW+1)'(NUM_CORES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_EXHAUSTED = 2'd2
    } state_t;

    state_t                r_state;
    logic [NONCE_BITS-1:0] r_base;
    logic [NONCE_BITS-1:0] r_nonce;
    logic [NONCE_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW:0]           r_count;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_overflow;
    logic [15:0]           r_found;

    logic                  w_start, w_proc, w_flush, w_pop, w_push_req, w_push, w_final;
    logic [NONCE_BITS-1:0] w_base, w_nonce, w_head_next;
    logic [NONCE_BITS:0]   w_sum;
    logic [AW-1:0]         w_rd_next;
    logic [AW:0]           w_count_next;
    logic [15:0]           w_found_base, w_found_next;

    always_comb begin
        w_start    = bus.valid_i & bus.new_block_i;
        w_proc     = w_start | (bus.valid_i & (r_state == S_RUN));
        w_base     = w_start ? '0 : r_base;
        w_nonce    = w_base + NONCE_BITS'(bus.core_index_i);
        // Carry out of the widened sum means the next round's nonces would not fit.
        w_sum      = {1'b0, w_base} + SPAN;
        w_final    = w_sum[NONCE_BITS];
`ifdef LATTICE_COLLECT_FLUSH_EN
        w_flush    = w_start;
`else
        w_flush    = 1'b0;
`endif
        w_pop      = r_valid & bus.nonce_ready_i & ~w_flush;
        w_push_req = w_proc & bus.success_i;
        w_push     = w_push_req & (w_flush | (r_count != DEPTH) | w_pop);

        w_rd_next    = w_flush ? r_wr_ptr : (w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr);
        w_count_next = (w_flush ? '0 : r_count - {{AW{1'b0}}, w_pop}) + {{AW{1'b0}}, w_push};

        // The new head is the incoming nonce only when it lands in an otherwise empty queue.
        if (w_count_next == '0)
            w_head_next = '0;
        else if (w_push && (r_wr_ptr == w_rd_next))
            w_head_next = w_nonce;
        else
            w_head_next = r_mem[w_rd_next];

        w_found_base = w_start ? 16'h0000 : r_found;
        w_found_next = (w_push && (w_found_base != 16'hFFFF)) ? w_found_base + 16'h0001 : w_found_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_nonce    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_found    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_done     <= w_proc & w_final;
            r_overflow <= r_overflow | (w_push_req & ~w_push);
            r_found    <= w_found_next;
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_count_next;
            r_valid    <= (w_count_next != '0);
            r_nonce    <= w_head_next;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_nonce;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_proc) begin
                r_state <= w_final ? S_EXHAUSTED : S_RUN;
                r_base  <= w_final ? w_base : w_base + STEP;
            end
        end
    end

    assign bus.nonce_o       = r_nonce;
    assign bus.nonce_valid_o = r_valid;
    assign bus.block_done_o  = r_done;
    assign bus.overflow_o    = r_overflow;
    assign bus.found_count_o = r_found;
    assign bus.state_o       = r_state;

    a_core_index_legal: assert property (@(posedge clk) disable iff (rst)
        (bus.valid_i && bus.success_i) |-> ({1'b0, bus.core_index_i} < CORES_LIM));
endmodule

// File: tb/tb_lattice_result_collector.sv
// Self-checking bench: a 32-bit collector for the main scenarios and an 8-bit one for nonce exhaustion.
`timescale 1ns/1ps
module tb_lattice_result_collector;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lattice_result_collector_if #(.NUM_CORES(10), .NONCE_BITS(32)) bus ();
    lattice_result_collector_if #(.NUM_CORES(10), .NONCE_BITS(8))  bus8 ();

    lattice_result_collector #(.NUM_CORES(10), .NONCE_BITS(32), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    lattice_result_collector #(.NUM_CORES(10), .NONCE_BITS(8), .FIFO_DEPTH(4)) u_dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp8_q[$];

    task automatic drive(input logic v, input logic nb, input logic s, input logic [3:0] idx);
        bus.valid_i = v; bus.new_block_i = nb; bus.success_i = s; bus.core_index_i = idx;
    endtask

    task automatic drive8(input logic v, input logic nb, input logic s, input logic [3:0] idx);
        bus8.valid_i = v; bus8.new_block_i = nb; bus8.success_i = s; bus8.core_index_i = idx;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive8(0, 0, 0, 0);
        bus.nonce_ready_i = 1'b0;
        bus8.nonce_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.nonce_o !== 32'h0) begin errors++; $display("FAIL reset_nonce got %0h exp 0", bus.nonce_o); end
        checks++; if (bus.nonce_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.nonce_valid_o); end
        checks++; if (bus.block_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.block_done_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow_o); end
        checks++; if (bus.found_count_o !== 16'h0) begin errors++; $display("FAIL reset_found got %0d exp 0", bus.found_count_o); end
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state_o); end
        checks++; if (bus8.nonce_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid8 got %b exp 0", bus8.nonce_valid_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        drive(1, 0, 1, 2);
        @(negedge clk);
        drive(0, 0, 0, 0);
        checks++; if (bus.nonce_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", bus.nonce_valid_o); end
        checks++; if (bus.found_count_o !== 16'h0) begin errors++; $display("FAIL idle_found got %0d exp 0", bus.found_count_o); end
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL idle_state got %0d exp 0", bus.state_o); end
    endtask

    task automatic test_basic();
        bus.nonce_ready_i = 1'b0;
        drive(1, 1, 1, 3); exp_q.push_back(32'd3);
        @(negedge clk);
        drive(1, 0, 0, 0);
        checks++; if (bus.nonce_valid_o !== 1'b1 || bus.nonce_o !== 32'd3) begin
            errors++; $display("FAIL basic_latency got v=%b n=%0d exp v=1 n=3", bus.nonce_valid_o, bus.nonce_o); end
        @(negedge clk);
        drive(1, 0, 1, 7); exp_q.push_back(32'd27);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        checks++; if (bus.found_count_o !== 16'd2) begin errors++; $display("FAIL basic_found got %0d exp 2", bus.found_count_o); end
        checks++; if (bus.nonce_o !== 32'd3) begin errors++; $display("FAIL basic_hold got %0d exp 3", bus.nonce_o); end
        bus.nonce_ready_i = 1'b1;
        for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
            if (bus.nonce_valid_o) begin
                checks++; if (bus.nonce_o !== exp_q[0]) begin errors++; $display("FAIL basic_order got %0d exp %0d", bus.nonce_o, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        bus.nonce_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0 || bus.nonce_valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), bus.nonce_valid_o); end
        exp_q.delete();
    endtask

    task automatic test_exhaust();
        int       done_cnt;
        logic [7:0] b;
        logic     s;
        logic [3:0] idx;
        done_cnt = 0;
        b = 8'd0;
        bus8.nonce_ready_i = 1'b1;
        for (int r = 0; r < 30; r++) begin
            checks++; if (bus8.block_done_o !== (r == 25)) begin
                errors++; $display("FAIL exhaust_done r=%0d got %b exp %b", r, bus8.block_done_o, (r == 25)); end
            if (bus8.block_done_o) done_cnt++;
            if (bus8.nonce_valid_o) begin
                checks++; if (exp8_q.size() == 0 || bus8.nonce_o !== exp8_q[0]) begin
                    errors++; $display("FAIL exhaust_nonce got %0d exp %0d", bus8.nonce_o, (exp8_q.size() != 0) ? exp8_q[0] : 8'hxx); end
                if (exp8_q.size() != 0) void'(exp8_q.pop_front());
            end
            if (r < 26) begin
                s = (r == 25) ? 1'b1 : 1'($urandom_range(0, 1));
                idx = 4'($urandom_range(0, 9));
                drive8(1, (r == 0), s, idx);
                if (s && r < 25) exp8_q.push_back(8'(b + 8'(idx)));
                b = 8'(b + 8'd10);
            end else begin
                drive8(0, 0, 0, 0);
            end
            @(negedge clk);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL exhaust_pulses got %0d exp 1", done_cnt); end
        checks++; if (exp8_q.size() != 0 || bus8.nonce_valid_o !== 1'b0) begin
            errors++; $display("FAIL exhaust_ignored got left=%0d v=%b exp left=0 v=0", exp8_q.size(), bus8.nonce_valid_o); end
        checks++; if (bus8.state_o !== 2'd2) begin errors++; $display("FAIL exhaust_state got %0d exp 2", bus8.state_o); end
        drive8(1, 1, 1, 0);
        @(negedge clk);
        drive8(0, 0, 0, 0);
        checks++; if (bus8.nonce_valid_o !== 1'b1 || bus8.nonce_o !== 8'd0) begin
            errors++; $display("FAIL exhaust_restart got v=%b n=%0d exp v=1 n=0", bus8.nonce_valid_o, bus8.nonce_o); end
        @(negedge clk);
        checks++; if (bus8.nonce_valid_o !== 1'b0 || bus8.state_o !== 2'd1) begin
            errors++; $display("FAIL exhaust_after got v=%b st=%0d exp v=0 st=1", bus8.nonce_valid_o, bus8.state_o); end
        bus8.nonce_ready_i = 1'b0;
        exp8_q.delete();
    endtask

    task automatic test_overflow();
        for (int r = 0; r < 6; r++) begin
            bus.nonce_ready_i = (r == 4);
            if (r == 4) begin
                checks++; if (bus.nonce_o !== exp_q[0]) begin errors++; $display("FAIL ovf_head got %0d exp %0d", bus.nonce_o, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            drive(1, (r == 0), 1, 4'(r));
            if (r < 5) exp_q.push_back(32'(11 * r));
            @(negedge clk);
            if (r == 3) begin
                checks++; if (bus.found_count_o !== 16'd4 || bus.overflow_o !== 1'b0) begin
                    errors++; $display("FAIL ovf_full got f=%0d o=%b exp f=4 o=0", bus.found_count_o, bus.overflow_o); end
            end
            if (r == 4) begin
                checks++; if (bus.found_count_o !== 16'd5 || bus.overflow_o !== 1'b0) begin
                    errors++; $display("FAIL ovf_pushpop got f=%0d o=%b exp f=5 o=0", bus.found_count_o, bus.overflow_o); end
            end
        end
        drive(0, 0, 0, 0);
        bus.nonce_ready_i = 1'b0;
        checks++; if (bus.overflow_o !== 1'b1 || bus.found_count_o !== 16'd5) begin
            errors++; $display("FAIL ovf_drop got o=%b f=%0d exp o=1 f=5", bus.overflow_o, bus.found_count_o); end
        bus.nonce_ready_i = 1'b1;
        for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
            if (bus.nonce_valid_o) begin
                checks++; if (bus.nonce_o !== exp_q[0]) begin errors++; $display("FAIL ovf_order got %0d exp %0d", bus.nonce_o, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        bus.nonce_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0 || bus.nonce_valid_o !== 1'b0) begin
            errors++; $display("FAIL ovf_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), bus.nonce_valid_o); end
        exp_q.delete();
    endtask

    task automatic test_flush();
        bus.nonce_ready_i = 1'b0;
        drive(1, 1, 1, 1); exp_q.push_back(32'd1);
        @(negedge clk);
        drive(1, 0, 1, 2); exp_q.push_back(32'd12);
        @(negedge clk);
        drive(1, 0, 1, 3); exp_q.push_back(32'd23);
        @(negedge clk);
        drive(1, 1, 1, 5);
`ifdef LATTICE_COLLECT_FLUSH_EN
        exp_q.delete();
`endif
        exp_q.push_back(32'd5);
        @(negedge clk);
        drive(0, 0, 0, 0);
        checks++; if (bus.found_count_o !== 16'd1) begin errors++; $display("FAIL flush_found got %0d exp 1", bus.found_count_o); end
        checks++; if (bus.nonce_o !== exp_q[0]) begin errors++; $display("FAIL flush_head got %0d exp %0d", bus.nonce_o, exp_q[0]); end
        bus.nonce_ready_i = 1'b1;
        for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
            if (bus.nonce_valid_o) begin
                checks++; if (bus.nonce_o !== exp_q[0]) begin errors++; $display("FAIL flush_order got %0d exp %0d", bus.nonce_o, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        bus.nonce_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0 || bus.nonce_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), bus.nonce_valid_o); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] b;
        int          fc;
        logic        rdy, pop, full_before, s;
        logic [3:0]  idx;
        b = 32'd0;
        fc = 0;
        for (int r = 0; r < 40; r++) begin
            checks++; if (bus.nonce_valid_o !== (exp_q.size() != 0)) begin
                errors++; $display("FAIL b2b_valid r=%0d got %b exp %b", r, bus.nonce_valid_o, (exp_q.size() != 0)); end
            rdy = 1'($urandom_range(0, 1));
            pop = rdy && (exp_q.size() != 0);
            if (pop) begin
                checks++; if (bus.nonce_o !== exp_q[0]) begin errors++; $display("FAIL b2b_nonce got %0d exp %0d", bus.nonce_o, exp_q[0]); end
            end
            full_before = (exp_q.size() == 4);
            if (pop) void'(exp_q.pop_front());
            s = ($urandom_range(0, 3) != 0);
            idx = 4'($urandom_range(0, 9));
            bus.nonce_ready_i = rdy;
            drive(1, (r == 0), s, idx);
            if (s && (!full_before || pop)) begin
                exp_q.push_back(b + 32'(idx));
                fc++;
            end
            b = b + 32'd10;
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        checks++; if (bus.found_count_o !== 16'(fc)) begin errors++; $display("FAIL b2b_found got %0d exp %0d", bus.found_count_o, fc); end
        bus.nonce_ready_i = 1'b1;
        for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
            if (bus.nonce_valid_o) begin
                checks++; if (bus.nonce_o !== exp_q[0]) begin errors++; $display("FAIL b2b_order got %0d exp %0d", bus.nonce_o, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        bus.nonce_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0 || bus.nonce_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), bus.nonce_valid_o); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bus.nonce_ready_i = 1'b0;
        drive(1, 1, 1, 2);
        @(negedge clk);
        drive(1, 0, 1, 4);
        @(negedge clk);
        drive(1, 0, 1, 6);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        checks++; if (bus.nonce_valid_o !== 1'b0 || bus.nonce_o !== 32'd0) begin
            errors++; $display("FAIL rstmid_nonce got v=%b n=%0d exp v=0 n=0", bus.nonce_valid_o, bus.nonce_o); end
        checks++; if (bus.found_count_o !== 16'd0 || bus.overflow_o !== 1'b0 || bus.block_done_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_status got f=%0d o=%b d=%b exp 0 0 0", bus.found_count_o, bus.overflow_o, bus.block_done_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.nonce_valid_o !== 1'b0 || bus.found_count_o !== 16'd0 || bus.state_o !== 2'd0) begin
                errors++; $display("FAIL rstmid_hold got v=%b f=%0d st=%0d exp 0 0 0", bus.nonce_valid_o, bus.found_count_o, bus.state_o); end
        end
        drive(1, 1, 1, 6);
        @(negedge clk);
        drive(0, 0, 0, 0);
        checks++; if (bus.nonce_valid_o !== 1'b1 || bus.nonce_o !== 32'd6 || bus.found_count_o !== 16'd1) begin
            errors++; $display("FAIL rstmid_restart got v=%b n=%0d f=%0d exp v=1 n=6 f=1", bus.nonce_valid_o, bus.nonce_o, bus.found_count_o); end
        bus.nonce_ready_i = 1'b1;
        @(negedge clk);
        bus.nonce_ready_i = 1'b0;
        checks++; if (bus.nonce_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_drain got %b exp 0", bus.nonce_valid_o); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic();
        test_exhaust();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
